// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared external 16-bit SRAM: the fetch and data ports get
// round-robin grants, and each transaction is a fixed-length IDLE -> ACCESS -> DONE sequence.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] LAST_CNT    = 3'(WAIT_CYCLES - 1);
  localparam logic       OWNER_FETCH = 1'b0;
  localparam logic       OWNER_DATA  = 1'b1;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              grant_data;
  logic              in_access;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;
    // On a tie the port that was not served last wins.
    grant_data   = d_req && (!i_req || (last_owner_q == OWNER_FETCH));
    unique case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          owner_d = grant_data ? OWNER_DATA : OWNER_FETCH;
          addr_d  = grant_data ? d_addr : i_addr;
          we_d    = grant_data && d_we;
          wdata_d = grant_data ? d_wdata : '0;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d      = DONE;
          last_owner_d = owner_q;
          if (!we_q) begin
            if (owner_q == OWNER_DATA) d_rdata_d = SRAM_DQ;
            else                       i_rdata_d = SRAM_DQ;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_FETCH;
      last_owner_q <= OWNER_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);

  // WE_N rises one cycle before the access ends so the data hold time is met.
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = !in_access;
  assign SRAM_UB_N = !in_access;
  assign SRAM_LB_N = !in_access;
  assign SRAM_OE_N = !(in_access && !we_q);
  assign SRAM_WE_N = !(in_access && we_q && (cnt_q != LAST_CNT));
  assign SRAM_DQ   = (in_access && we_q) ? wdata_q : {DATA_W{1'bz}};

  assign d_rdata = d_rdata_q;
  assign i_rdata = i_rdata_q;
  assign d_done  = (state_q == DONE) && (owner_q == OWNER_DATA);
  assign i_done  = (state_q == DONE) && (owner_q == OWNER_FETCH);
  assign d_stall = d_req && !d_done;
  assign i_stall = i_req && !i_done;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, read, write, tie, round-robin and dropped-request
// sequences against a small behavioural SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we;
  logic [17:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done, d_stall;
  logic        i_req;
  logic [17:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done, i_stall;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:255];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc_ctr = 0;
  int          d_pulses = 0;
  int          i_pulses = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(5), .ADDR_W(18), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
  );

  // Asynchronous-read SRAM model, write committed on the clock while WE_N is low.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_ctr++;
    if (d_done) d_pulses++;
    if (i_done) i_pulses++;
  endtask

  // Issues one data-port request and returns the cycle count until d_done (0 on timeout).
  task automatic d_xfer(input logic we, input logic [17:0] addr, input logic [15:0] wd,
                        output int lat);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (d_done) begin
        lat = k;
        break;
      end
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  int lat;
  int d_at, i_at, i_stall_gaps, p0;
  int rr_cyc [4];
  int rr_own [4];
  int rr_n;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[8'h10] = 16'h1234;
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_addr = '0;
    tick(); tick();
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_i_rdata", 32'(i_rdata), 32'd0);
    chk("rst_dones", 32'({d_done, i_done}), 32'd0);

    // Reset in the middle of a write.
    rst = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 18'h00040; d_wdata = 16'hBEEF;
    tick();
    chk("a_we_n_c0", 32'(sram_we_n), 32'd0);
    tick(); tick();
    chk("a_ce_n_c2", 32'(sram_ce_n), 32'd0);
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("a_we_n_after_rst", 32'(sram_we_n), 32'd1);
    chk("a_ce_n_after_rst", 32'(sram_ce_n), 32'd1);
    chk("a_addr_after_rst", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("a_no_d_done", 32'(d_pulses), 32'd0);
    chk("a_d_rdata", 32'(d_rdata), 32'd0);

    // Data read of 0x00010.
    d_req = 1'b1; d_we = 1'b0; d_addr = 18'h00010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("rd_oe_n_c%0d", k), 32'({sram_oe_n, sram_we_n, d_done}), 32'b010);
    end
    tick();
    chk("rd_done", 32'(d_done), 32'd1);
    chk("rd_rdata", 32'(d_rdata), 32'h1234);
    chk("rd_stall", 32'(d_stall), 32'd0);
    chk("rd_oe_n_done", 32'(sram_oe_n), 32'd1);
    d_req = 1'b0;
    tick();
    chk("rd_done_once", 32'(d_done), 32'd0);
    chk("rd_rdata_hold", 32'(d_rdata), 32'h1234);

    // Data write of 0xA5A5 to 0x00020.
    d_req = 1'b1; d_we = 1'b1; d_addr = 18'h00020; d_wdata = 16'hA5A5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("wr_dq_c%0d", k), 32'(sram_dq), 32'hA5A5);
      chk($sformatf("wr_ctl_c%0d", k), 32'({sram_we_n, sram_oe_n, sram_ce_n, d_stall}),
          (k < 5) ? 32'b0101 : 32'b1101);
    end
    tick();
    chk("wr_done", 32'(d_done), 32'd1);
    chk("wr_keeps_d_rdata", 32'(d_rdata), 32'h1234);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    d_xfer(1'b0, 18'h00020, 16'h0000, lat);
    chk("rdback_lat", 32'(lat), 32'd6);
    chk("rdback_data", 32'(d_rdata), 32'hA5A5);

    // Tie right after reset: data first, fetch at T+13.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 18'h00010;
    i_req = 1'b1; i_addr = 18'h00020;
    d_at = 0; i_at = 0; i_stall_gaps = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (d_done) begin
        d_at = k;
        d_req = 1'b0;
      end
      if (i_done) begin
        i_at = k;
        i_req = 1'b0;
        break;
      end
      if (!i_stall) i_stall_gaps++;
    end
    chk("tie_d_done_at", 32'(d_at), 32'd6);
    chk("tie_i_done_at", 32'(i_at), 32'd13);
    chk("tie_i_stall_held", 32'(i_stall_gaps), 32'd0);
    chk("tie_d_rdata", 32'(d_rdata), 32'h1234);
    chk("tie_i_rdata", 32'(i_rdata), 32'hA5A5);
    tick();

    // Both ports held high: grants alternate D, I, D, I.
    d_req = 1'b1; i_req = 1'b1; d_addr = 18'h00010; i_addr = 18'h00020;
    rr_n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (d_done || i_done) begin
        rr_cyc[rr_n] = k;
        rr_own[rr_n] = d_done ? 1 : 0;
        rr_n++;
        if (rr_n == 4) break;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("rr_count", 32'(rr_n), 32'd4);
    for (int j = 0; j < rr_n; j++) begin
      chk($sformatf("rr_owner_%0d", j), 32'(rr_own[j]), (j % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_cycle_%0d", j), 32'(rr_cyc[j]), 32'(6 + 7 * j));
    end
    tick();

    // Fetch request dropped after ACCESS cnt=1 still completes once.
    p0 = i_pulses;
    i_req = 1'b1; i_addr = 18'h00010;
    i_at = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) i_req = 1'b0;
      if (i_done && i_at == 0) begin
        i_at = k;
        chk("drop_i_stall", 32'(i_stall), 32'd0);
      end
    end
    chk("drop_done_at", 32'(i_at), 32'd6);
    chk("drop_one_pulse", 32'(i_pulses - p0), 32'd1);
    chk("drop_i_rdata", 32'(i_rdata), 32'h1234);
    chk("drop_idle_ce_n", 32'(sram_ce_n), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
